// File: rtl/axi_hp_write_arbiter_if.sv
// One AXI3 write-only port (AW, W, B). The arbiter takes two as slave-side
// sources and drives one towards the PS HP port as master.
interface axi_hp_write_arbiter_if #(
   parameter int ID_W   = 6,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
);
   // Every channel uses standard AXI valid/ready: a beat transfers on the rising
   // edge where both are high, and the sender holds its payload stable until then.
   logic [ID_W-1:0]     awid;
   logic [ADDR_W-1:0]   awaddr;
   logic [3:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic [3:0]          awcache;
   logic                awvalid;
   logic                awready;
   logic [ID_W-1:0]     wid;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;
   logic [ID_W-1:0]     bid;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/axi_hp_write_arbiter.sv
// Two-to-one AXI3 write arbiter: round-robin AW grants, W routed in grant order
// through a small order FIFO, B routed back by the source bit in the ID MSB.
module axi_hp_write_arbiter #(
   parameter int AXI_ID_WIDTH   = 6,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int ORDER_DEPTH    = 4
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   axi_hp_write_arbiter_if.slave         s0_axi,
   axi_hp_write_arbiter_if.slave         s1_axi,
   axi_hp_write_arbiter_if.master        m_axi,
   output logic [1:0]                    sts_data,
   output logic                          dbg_state_o
);
   localparam int PW = $clog2(ORDER_DEPTH);
   localparam int IW = AXI_ID_WIDTH;

   typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_e;

   state_e                      state_q;
   logic                        last_q;
   logic [ORDER_DEPTH-1:0]      fifo_q;
   logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
   logic [PW:0]                 count_q, count_d;
   logic [1:0]                  sts_q, sts_d;
   logic [IW-1:0]               awid_q;
   logic [AXI_ADDR_WIDTH-1:0]   awaddr_q;
   logic [3:0]                  awlen_q, awcache_q;
   logic [2:0]                  awsize_q;
   logic [1:0]                  awburst_q;

   logic          full, empty, head, gnt_valid, gnt_idx, pop, b_sel;
   logic [PW-1:0] off;
   logic          unused_id_msbs;

   assign full  = (count_q == (PW+1)'(ORDER_DEPTH));
   assign empty = (count_q == '0);
   assign head  = fifo_q[rd_ptr_q];

   // On a tie the source that did not win last time gets the grant.
   always_comb begin
      gnt_idx = s1_axi.awvalid;
      if (s0_axi.awvalid && s1_axi.awvalid) gnt_idx = ~last_q;
   end

   assign gnt_valid      = aresetn && (state_q == ST_IDLE) && !full &&
                           (s0_axi.awvalid || s1_axi.awvalid);
   assign s0_axi.awready = gnt_valid && !gnt_idx;
   assign s1_axi.awready = gnt_valid && gnt_idx;

   assign m_axi.awvalid = (state_q == ST_ISSUE);
   assign m_axi.awid    = awid_q;
   assign m_axi.awaddr  = awaddr_q;
   assign m_axi.awlen   = awlen_q;
   assign m_axi.awsize  = awsize_q;
   assign m_axi.awburst = awburst_q;
   assign m_axi.awcache = awcache_q;

   assign m_axi.wvalid  = !empty && (head ? s1_axi.wvalid : s0_axi.wvalid);
   assign m_axi.wid     = {head, head ? s1_axi.wid[IW-2:0] : s0_axi.wid[IW-2:0]};
   assign m_axi.wdata   = head ? s1_axi.wdata : s0_axi.wdata;
   assign m_axi.wstrb   = head ? s1_axi.wstrb : s0_axi.wstrb;
   assign m_axi.wlast   = head ? s1_axi.wlast : s0_axi.wlast;
   assign s0_axi.wready = !empty && !head && m_axi.wready;
   assign s1_axi.wready = !empty && head && m_axi.wready;
   assign pop           = m_axi.wvalid && m_axi.wready && m_axi.wlast;

   assign b_sel         = m_axi.bid[IW-1];
   assign s0_axi.bvalid = aresetn && m_axi.bvalid && !b_sel;
   assign s1_axi.bvalid = aresetn && m_axi.bvalid && b_sel;
   assign s0_axi.bid    = {1'b0, m_axi.bid[IW-2:0]};
   assign s1_axi.bid    = {1'b0, m_axi.bid[IW-2:0]};
   assign s0_axi.bresp  = m_axi.bresp;
   assign s1_axi.bresp  = m_axi.bresp;
   assign m_axi.bready  = aresetn && m_axi.bvalid && (b_sel ? s1_axi.bready : s0_axi.bready);

   assign unused_id_msbs = ^{s0_axi.awid[IW-1], s1_axi.awid[IW-1],
                             s0_axi.wid[IW-1], s1_axi.wid[IW-1]};

   always_comb begin
      count_d = count_q;
      if (gnt_valid && !pop)      count_d = count_q + 1'b1;
      else if (!gnt_valid && pop) count_d = count_q - 1'b1;
   end

   // An entry is live when its distance from the read pointer is below the count.
   always_comb begin
      sts_d = '0;
      off   = '0;
      for (int i = 0; i < ORDER_DEPTH; i++) begin
         off = PW'(i) - rd_ptr_q;
         if ({1'b0, off} < count_q) sts_d[fifo_q[i]] = 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q   <= ST_IDLE;
         last_q    <= 1'b1;
         fifo_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         sts_q     <= '0;
         awid_q    <= '0;
         awaddr_q  <= '0;
         awlen_q   <= '0;
         awsize_q  <= '0;
         awburst_q <= '0;
         awcache_q <= '0;
      end else begin
         count_q <= count_d;
         sts_q   <= sts_d;
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (gnt_valid) begin
                  fifo_q[wr_ptr_q] <= gnt_idx;
                  wr_ptr_q  <= wr_ptr_q + 1'b1;
                  last_q    <= gnt_idx;
                  awid_q    <= {gnt_idx, gnt_idx ? s1_axi.awid[IW-2:0] : s0_axi.awid[IW-2:0]};
                  awaddr_q  <= gnt_idx ? s1_axi.awaddr  : s0_axi.awaddr;
                  awlen_q   <= gnt_idx ? s1_axi.awlen   : s0_axi.awlen;
                  awsize_q  <= gnt_idx ? s1_axi.awsize  : s0_axi.awsize;
                  awburst_q <= gnt_idx ? s1_axi.awburst : s0_axi.awburst;
                  awcache_q <= gnt_idx ? s1_axi.awcache : s0_axi.awcache;
                  state_q   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (m_axi.awready) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign sts_data    = sts_q;
   assign dbg_state_o = state_q;
endmodule

// File: tb/tb_axi_hp_write_arbiter.sv
// Directed bench for axi_hp_write_arbiter: single source, contention, full
// order FIFO, AW backpressure with random W gaps, push/pop overlap, mid-burst reset.
`timescale 1ns/1ps
module tb_axi_hp_write_arbiter;
   localparam int IW = 6;
   localparam int AW = 32;
   localparam int DW = 64;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic [1:0]    sts_data;
   logic          dbg_state;
   int            n_assert = 0;
   int            n_fail   = 0;
   int            beat;
   logic [DW-1:0] exp_q[$];

   axi_hp_write_arbiter_if #(.ID_W(IW), .ADDR_W(AW), .DATA_W(DW)) s0_if ();
   axi_hp_write_arbiter_if #(.ID_W(IW), .ADDR_W(AW), .DATA_W(DW)) s1_if ();
   axi_hp_write_arbiter_if #(.ID_W(IW), .ADDR_W(AW), .DATA_W(DW)) m_if ();

   axi_hp_write_arbiter #(
      .AXI_ID_WIDTH(IW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .ORDER_DEPTH(4)
   ) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .s0_axi      (s0_if),
      .s1_axi      (s1_if),
      .m_axi       (m_if),
      .sts_data    (sts_data),
      .dbg_state_o (dbg_state)
   );

   always #5 aclk = ~aclk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic init_inputs();
      s0_if.awvalid = 0; s0_if.awid = '0; s0_if.awaddr = '0; s0_if.awlen = '0;
      s0_if.awsize = '0; s0_if.awburst = '0; s0_if.awcache = '0;
      s1_if.awvalid = 0; s1_if.awid = '0; s1_if.awaddr = '0; s1_if.awlen = '0;
      s1_if.awsize = '0; s1_if.awburst = '0; s1_if.awcache = '0;
      s0_if.wvalid = 0; s0_if.wid = '0; s0_if.wdata = '0; s0_if.wstrb = '0; s0_if.wlast = 0;
      s1_if.wvalid = 0; s1_if.wid = '0; s1_if.wdata = '0; s1_if.wstrb = '0; s1_if.wlast = 0;
      s0_if.bready = 0; s1_if.bready = 0;
      m_if.awready = 0; m_if.wready = 0;
      m_if.bvalid = 0; m_if.bid = '0; m_if.bresp = '0;
   endtask

   task automatic set_aw(input int src, input logic v, input logic [IW-1:0] id, input logic [AW-1:0] addr);
      if (src == 0) begin
         s0_if.awvalid = v; s0_if.awid = id; s0_if.awaddr = addr;
         s0_if.awlen = 4'hF; s0_if.awsize = 3'd3; s0_if.awburst = 2'd1; s0_if.awcache = 4'h3;
      end else begin
         s1_if.awvalid = v; s1_if.awid = id; s1_if.awaddr = addr;
         s1_if.awlen = 4'hF; s1_if.awsize = 3'd3; s1_if.awburst = 2'd1; s1_if.awcache = 4'h3;
      end
   endtask

   task automatic set_w(input int src, input logic v, input logic [DW-1:0] d, input logic l);
      if (src == 0) begin
         s0_if.wvalid = v; s0_if.wdata = d; s0_if.wlast = l; s0_if.wid = 6'h25; s0_if.wstrb = '1;
      end else begin
         s1_if.wvalid = v; s1_if.wdata = d; s1_if.wlast = l; s1_if.wid = 6'h0B; s1_if.wstrb = '1;
      end
   endtask

   // Full-rate burst from src; the other source offers a decoy beat throughout.
   task automatic stream_burst(input int src, input logic [DW-1:0] base, input string tag);
      for (int b = 0; b < 16; b++) begin
         set_w(src, 1'b1, base + 64'(b), b == 15);
         set_w(1 - src, 1'b1, 64'hDEAD, 1'b1);
         #1;
         check({tag, " data"}, m_if.wdata, base + 64'(b));
         check({tag, " wlast"}, m_if.wlast, b == 15);
         if (b == 0) begin
            check({tag, " wid msb"}, m_if.wid[IW-1], src == 1);
            check({tag, " decoy wready"}, (src == 0) ? s1_if.wready : s0_if.wready, 0);
         end
         @(negedge aclk);
      end
      set_w(0, 1'b0, '0, 1'b0);
      set_w(1, 1'b0, '0, 1'b0);
   endtask

   initial begin
      // reset state, with a B beat offered to show it stays blocked
      init_inputs();
      aresetn = 0;
      m_if.bvalid = 1; s0_if.bready = 1; s1_if.bready = 1;
      repeat (3) @(negedge aclk);
      #1;
      check("rst awvalid", m_if.awvalid, 0);
      check("rst awaddr", m_if.awaddr, 0);
      check("rst awid", m_if.awid, 0);
      check("rst wvalid", m_if.wvalid, 0);
      check("rst s0 awready", s0_if.awready, 0);
      check("rst s0 wready", s0_if.wready, 0);
      check("rst s0 bvalid", s0_if.bvalid, 0);
      check("rst bready", m_if.bready, 0);
      check("rst sts", sts_data, 0);
      init_inputs();
      @(negedge aclk);
      aresetn = 1;

      // single source
      set_aw(0, 1'b1, 6'h03, 32'h1000_0000);
      #1;
      check("t1 s0 awready", s0_if.awready, 1);
      check("t1 s1 awready", s1_if.awready, 0);
      @(negedge aclk);
      set_aw(0, 1'b0, 6'h03, 32'h1000_0000);
      #1;
      check("t1 awvalid", m_if.awvalid, 1);
      check("t1 awid", m_if.awid, 6'h03);
      check("t1 awaddr", m_if.awaddr, 32'h1000_0000);
      check("t1 awlen", m_if.awlen, 4'hF);
      m_if.awready = 1;
      @(negedge aclk);
      #1;
      check("t1 awvalid drop", m_if.awvalid, 0);
      check("t1 sts pending", sts_data, 2'b01);
      @(negedge aclk);
      m_if.wready = 1;
      stream_burst(0, 64'hA000, "t1");
      set_w(0, 1'b1, 64'h1, 1'b1);
      #1;
      check("t1 empty wvalid", m_if.wvalid, 0);
      check("t1 empty wready", s0_if.wready, 0);
      set_w(0, 1'b0, '0, 1'b0);
      @(negedge aclk);
      #1;
      check("t1 sts clear", sts_data, 2'b00);
      m_if.bvalid = 1; m_if.bid = 6'h03; m_if.bresp = 2'd0;
      s0_if.bready = 1; s1_if.bready = 1;
      #1;
      check("t1 b s0 valid", s0_if.bvalid, 1);
      check("t1 b s1 valid", s1_if.bvalid, 0);
      check("t1 b s0 id", s0_if.bid, 6'h03);
      check("t1 b bready", m_if.bready, 1);
      m_if.bid = 6'h25; m_if.bresp = 2'd2;
      #1;
      check("t1 b1 s1 valid", s1_if.bvalid, 1);
      check("t1 b1 s0 valid", s0_if.bvalid, 0);
      check("t1 b1 s1 id", s1_if.bid, 6'h05);
      check("t1 b1 s1 resp", s1_if.bresp, 2'd2);
      s1_if.bready = 0;
      #1;
      check("t1 b1 bready", m_if.bready, 0);
      init_inputs();
      @(negedge aclk);

      // contention from reset, then fill the order FIFO
      aresetn = 0;
      set_aw(0, 1'b1, 6'h25, 32'h2000_0000);
      set_aw(1, 1'b1, 6'h0B, 32'h2100_0000);
      m_if.awready = 1;
      @(negedge aclk);
      #1;
      check("t2 rst s0 awready", s0_if.awready, 0);
      check("t2 rst s1 awready", s1_if.awready, 0);
      @(negedge aclk);
      aresetn = 1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("t2 s0 grant", s0_if.awready, (k % 2) == 0);
         check("t2 s1 grant", s1_if.awready, (k % 2) == 1);
         @(negedge aclk);
         #1;
         check("t2 awvalid", m_if.awvalid, 1);
         check("t2 awid", m_if.awid, ((k % 2) == 0) ? 6'h05 : 6'h2B);
         @(negedge aclk);
      end
      #1;
      check("t3 full s0", s0_if.awready, 0);
      check("t3 full s1", s1_if.awready, 0);
      @(negedge aclk);
      #1;
      check("t3 full s0 again", s0_if.awready, 0);
      check("t3 sts both", sts_data, 2'b11);
      @(negedge aclk);
      m_if.wready = 1;
      for (int b = 0; b < 16; b++) begin
         set_w(0, 1'b1, 64'h1100 + 64'(b), b == 15);
         set_w(1, 1'b1, 64'hDEAD, 1'b1);
         #1;
         check("t3 b1 data", m_if.wdata, 64'h1100 + 64'(b));
         check("t3 full no grant", s0_if.awready | s1_if.awready, 0);
         @(negedge aclk);
      end
      set_w(0, 1'b0, '0, 1'b0);
      set_w(1, 1'b0, '0, 1'b0);
      #1;
      check("t3 grant after pop s0", s0_if.awready, 1);
      check("t3 grant after pop s1", s1_if.awready, 0);
      @(negedge aclk);
      set_aw(0, 1'b0, 6'h25, 32'h2000_0000);
      set_aw(1, 1'b0, 6'h0B, 32'h2100_0000);
      #1;
      check("t3 fifth awid", m_if.awid, 6'h05);
      stream_burst(1, 64'h2200, "t3 b2");
      stream_burst(0, 64'h3300, "t3 b3");
      stream_burst(1, 64'h4400, "t3 b4");
      stream_burst(0, 64'h5500, "t3 b5");

      // AW backpressure
      m_if.awready = 0;
      set_aw(1, 1'b1, 6'h11, 32'h2000_0040);
      #1;
      check("t4 s1 grant", s1_if.awready, 1);
      @(negedge aclk);
      set_aw(1, 1'b0, 6'h11, 32'h2000_0040);
      set_aw(0, 1'b1, 6'h04, 32'h2000_0080);
      for (int c = 0; c < 10; c++) begin
         #1;
         check("t4 awvalid hold", m_if.awvalid, 1);
         check("t4 awaddr hold", m_if.awaddr, 32'h2000_0040);
         check("t4 awid hold", m_if.awid, 6'h31);
         check("t4 no grant", s0_if.awready, 0);
         @(negedge aclk);
      end
      m_if.awready = 1;
      @(negedge aclk);
      #1;
      check("t4 s0 grant after", s0_if.awready, 1);
      @(negedge aclk);
      set_aw(0, 1'b0, 6'h04, 32'h2000_0080);

      // random wready gaps on the s1 burst
      for (int i = 0; i < 16; i++) exp_q.push_back(64'hB000 + 64'(i));
      beat = 0;
      for (int c = 0; c < 300 && beat < 16; c++) begin
         m_if.wready = 1'($urandom_range(0, 1));
         set_w(1, 1'b1, 64'hB000 + 64'(beat), beat == 15);
         #1;
         check("t4 rand wvalid", m_if.wvalid, 1);
         if (m_if.wready) begin
            check("t4 rand data", m_if.wdata, exp_q.pop_front());
            check("t4 rand wlast", m_if.wlast, beat == 15);
            beat++;
         end
         @(negedge aclk);
      end
      check("t4 rand beats", beat, 16);
      check("t4 rand queue", exp_q.size(), 0);
      set_w(1, 1'b0, '0, 1'b0);
      m_if.wready = 1;

      // grant in the same cycle as the s0 wlast pop
      for (int b = 0; b < 16; b++) begin
         set_w(0, 1'b1, 64'h6600 + 64'(b), b == 15);
         if (b == 15) set_aw(1, 1'b1, 6'h07, 32'h2000_00C0);
         #1;
         check("t5 data", m_if.wdata, 64'h6600 + 64'(b));
         if (b == 15) check("t5 push during pop", s1_if.awready, 1);
         @(negedge aclk);
      end
      set_aw(1, 1'b0, 6'h07, 32'h2000_00C0);
      set_w(0, 1'b1, 64'hDEAD, 1'b1);
      set_w(1, 1'b1, 64'h7700, 1'b0);
      #1;
      check("t5 head data", m_if.wdata, 64'h7700);
      check("t5 head s1 wready", s1_if.wready, 1);
      check("t5 head s0 wready", s0_if.wready, 0);
      check("t5 awid", m_if.awid, 6'h27);
      @(negedge aclk);
      for (int b = 1; b < 7; b++) begin
         set_w(1, 1'b1, 64'h7700 + 64'(b), 1'b0);
         #1;
         check("t6 data", m_if.wdata, 64'h7700 + 64'(b));
         if (b == 1) check("t5 sts after swap", sts_data, 2'b10);
         @(negedge aclk);
      end

      // reset at beat 7
      set_w(1, 1'b1, 64'h7707, 1'b0);
      set_aw(0, 1'b1, 6'h01, 32'h0);
      m_if.bvalid = 1; m_if.bid = 6'h20; s1_if.bready = 1;
      aresetn = 0;
      #1;
      check("t6 pre-reset wvalid", m_if.wvalid, 1);
      @(negedge aclk);
      #1;
      check("t6 rst wvalid", m_if.wvalid, 0);
      check("t6 rst s1 wready", s1_if.wready, 0);
      check("t6 rst awvalid", m_if.awvalid, 0);
      check("t6 rst awaddr", m_if.awaddr, 0);
      check("t6 rst s0 awready", s0_if.awready, 0);
      check("t6 rst sts", sts_data, 0);
      check("t6 rst s1 bvalid", s1_if.bvalid, 0);
      check("t6 rst bready", m_if.bready, 0);
      check("t6 rst state", dbg_state, 0);
      init_inputs();
      @(negedge aclk);
      aresetn = 1;
      set_aw(1, 1'b1, 6'h02, 32'h3000_0000);
      m_if.awready = 1; m_if.wready = 1;
      #1;
      check("t6 fresh grant", s1_if.awready, 1);
      @(negedge aclk);
      set_aw(1, 1'b0, 6'h02, 32'h3000_0000);
      #1;
      check("t6 fresh awvalid", m_if.awvalid, 1);
      check("t6 fresh awid", m_if.awid, 6'h22);
      check("t6 fresh awaddr", m_if.awaddr, 32'h3000_0000);
      @(negedge aclk);
      stream_burst(1, 64'hE000, "t6 fresh");
      #1;
      check("t6 fresh done", m_if.wvalid, 0);
      m_if.bvalid = 1; m_if.bid = 6'h22; m_if.bresp = 2'd0; s1_if.bready = 1;
      #1;
      check("t6 b s1 valid", s1_if.bvalid, 1);
      check("t6 b s1 id", s1_if.bid, 6'h02);
      check("t6 b s0 valid", s0_if.bvalid, 0);
      check("t6 b bready", m_if.bready, 1);
      init_inputs();
      @(negedge aclk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
